fetch_unit: RTL and testbench

Instruction fetch stage that sits directly upstream of the processor state machine. It watches the 6-bit state code, and on fetch1 issues a read of instruction memory at the program counter. It captures the returned word into the 16-bit instruction register (IR) that the state machine decodes in fetch3, then advances the PC. It owns the PC, the IR and the instruction-memory request/acknowledge handshake.

---
 rtl/fetch_unit.sv | 128 ++++++++++++
 tb/tb_fetch_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues an imem read on fetch1, captures the word into IR, advances PC.
// Optional `FETCH_TIMEOUT_EN aborts a fetch whose ack never arrives and sets a sticky fetch_err.
module fetch_unit #(
    parameter int                ADDR_W         = 8,
    parameter logic [ADDR_W-1:0] PC_RESET       = '0,
    parameter int                TIMEOUT_CYCLES = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [5:0]        state,
    input  logic              mem_ack,
    input  logic [15:0]       mem_rdata,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_load_value,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       IR,
    output logic [ADDR_W-1:0] PC,
    output logic              fetch_busy,
    output logic              fetch_done,
    output logic              fetch_err
);

    localparam logic [5:0] S_FETCH1 = 6'd1;

    typedef enum logic {
        F_IDLE,
        F_WAIT
    } fstate_t;

    fstate_t           r_state, w_next;
    logic              r_req, w_req;
    logic [ADDR_W-1:0] r_addr, w_addr;
    logic [15:0]       r_ir, w_ir;
    logic [ADDR_W-1:0] r_pc, w_pc;
    logic              r_done, w_done;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt, w_cnt;
    logic             r_err, w_err;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= F_IDLE;
            r_req   <= 1'b0;
            r_addr  <= '0;
            r_ir    <= 16'd0;
            r_pc    <= PC_RESET;
            r_done  <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            r_cnt   <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_req   <= w_req;
            r_addr  <= w_addr;
            r_ir    <= w_ir;
            r_pc    <= w_pc;
            r_done  <= w_done;
`ifdef FETCH_TIMEOUT_EN
            r_cnt   <= w_cnt;
            r_err   <= w_err;
`endif
        end
    end

    always_comb begin
        w_next = r_state;
        w_req  = r_req;
        w_addr = r_addr;
        w_ir   = r_ir;
        w_pc   = r_pc;
        w_done = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        w_cnt  = '0;
        w_err  = r_err;
`endif
        unique case (r_state)
            F_IDLE: begin
                if (state == S_FETCH1) begin
                    w_addr = r_pc;
                    w_req  = 1'b1;
                    w_next = F_WAIT;
                end
            end
            F_WAIT: begin
                if (mem_ack) begin
                    w_ir   = mem_rdata;
                    w_pc   = r_pc + ADDR_W'(1);
                    w_req  = 1'b0;
                    w_done = 1'b1;
                    w_next = F_IDLE;
                end
`ifdef FETCH_TIMEOUT_EN
                // r_cnt counts wait edges already spent; this edge is number r_cnt+1
                else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_ir   = 16'd0;
                    w_req  = 1'b0;
                    w_done = 1'b1;
                    w_err  = 1'b1;
                    w_next = F_IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
`endif
            end
        endcase
        if (pc_load) begin
            w_pc = pc_load_value;
        end
    end

    assign mem_req    = r_req;
    assign mem_addr   = r_addr;
    assign IR         = r_ir;
    assign PC         = r_pc;
    assign fetch_busy = (r_state == F_WAIT);
    assign fetch_done = r_done;
`ifdef FETCH_TIMEOUT_EN
    assign fetch_err  = r_err;
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: zero-wait, wait states, wrap/load, spurious inputs, timeout, reset.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [5:0]  state;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        pc_load;
    logic [7:0]  pc_load_value;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic [15:0] IR;
    logic [7:0]  PC;
    logic        fetch_busy;
    logic        fetch_done;
    logic        fetch_err;

    logic [15:0] mem [0:255];
    int n_checks;
    int n_fail;

    fetch_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .state         (state),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .IR            (IR),
        .PC            (PC),
        .fetch_busy    (fetch_busy),
        .fetch_done    (fetch_done),
        .fetch_err     (fetch_err)
    );

    assign mem_rdata = mem[mem_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'd0;
        mem[0]   = 16'd6;
        mem[1]   = 16'hA5A5;
        mem[2]   = 16'h1234;
        mem[255] = 16'hBEEF;
        mem[8'h40] = 16'h0F0F;
        reset_n = 1'b0;
        state = 6'd0;
        mem_ack = 1'b0;
        pc_load = 1'b0;
        pc_load_value = 8'h00;

        tick();
        tick();
        check("rst_req", mem_req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_ir", IR, 0);
        check("rst_pc", PC, 0);
        check("rst_busy", fetch_busy, 0);
        check("rst_done", fetch_done, 0);
        check("rst_err", fetch_err, 0);
        reset_n = 1'b1;

        // idle with state 0: never requests
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_req", mem_req, 0);
        end

        // zero-wait fetch of word 0
        mem_ack = 1'b1;
        state = 6'd1;
        tick();
        check("zw_req", mem_req, 1);
        check("zw_addr", mem_addr, 0);
        check("zw_busy", fetch_busy, 1);
        check("zw_ir_pre", IR, 0);
        state = 6'd2;
        tick();
        check("zw_ir", IR, 16'd6);
        check("zw_pc", PC, 1);
        check("zw_done", fetch_done, 1);
        check("zw_req_off", mem_req, 0);
        state = 6'd3;
        tick();
        check("zw_done_off", fetch_done, 0);
        check("zw_ir_hold", IR, 16'd6);
        state = 6'd0;

        // three wait states
        mem_ack = 1'b0;
        state = 6'd1;
        tick();
        check("ws_req", mem_req, 1);
        check("ws_addr", mem_addr, 1);
        state = 6'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ws_req_hold", mem_req, 1);
            check("ws_addr_hold", mem_addr, 1);
            check("ws_busy", fetch_busy, 1);
            check("ws_ir_hold", IR, 16'd6);
            check("ws_done0", fetch_done, 0);
        end
        mem_ack = 1'b1;
        tick();
        check("ws_ir", IR, 16'hA5A5);
        check("ws_pc", PC, 2);
        check("ws_done", fetch_done, 1);
        check("ws_busy_off", fetch_busy, 0);
        check("ws_req_off", mem_req, 0);

        // spurious ack in idle, then state=1 held during wait
        tick();
        check("sp_ir", IR, 16'hA5A5);
        check("sp_done", fetch_done, 0);
        check("sp_req", mem_req, 0);
        mem_ack = 1'b0;
        state = 6'd1;
        tick();
        check("sp_req1", mem_req, 1);
        check("sp_addr", mem_addr, 2);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("sp_req_hold", mem_req, 1);
            check("sp_addr_hold", mem_addr, 2);
        end
        mem_ack = 1'b1;
        tick();
        check("sp_ir2", IR, 16'h1234);
        check("sp_pc", PC, 3);
        check("sp_req_off", mem_req, 0);
        state = 6'd0;
        mem_ack = 1'b0;
        tick();
        check("sp_no_second", mem_req, 0);
        check("sp_pc_hold", PC, 3);

        // PC wrap from FF
        pc_load = 1'b1;
        pc_load_value = 8'hFF;
        tick();
        check("ld_pc_ff", PC, 8'hFF);
        pc_load = 1'b0;
        mem_ack = 1'b1;
        state = 6'd1;
        tick();
        check("wr_addr", mem_addr, 8'hFF);
        state = 6'd0;
        tick();
        check("wr_ir", IR, 16'hBEEF);
        check("wr_pc", PC, 8'h00);

        // load on the capture edge wins over increment
        state = 6'd1;
        tick();
        check("lc_addr", mem_addr, 0);
        state = 6'd0;
        pc_load = 1'b1;
        pc_load_value = 8'h40;
        tick();
        check("lc_pc", PC, 8'h40);
        check("lc_ir", IR, 16'd6);
        check("lc_done", fetch_done, 1);
        pc_load = 1'b0;

        // load during an outstanding request keeps mem_addr
        mem_ack = 1'b0;
        state = 6'd1;
        tick();
        check("lw_addr", mem_addr, 8'h40);
        state = 6'd0;
        pc_load = 1'b1;
        pc_load_value = 8'h10;
        tick();
        check("lw_pc", PC, 8'h10);
        check("lw_addr_hold", mem_addr, 8'h40);
        check("lw_req_hold", mem_req, 1);
        pc_load = 1'b0;
        mem_ack = 1'b1;
        tick();
        check("lw_ir", IR, 16'h0F0F);
        check("lw_pc_inc", PC, 8'h11);
        mem_ack = 1'b0;

`ifdef FETCH_TIMEOUT_EN
        state = 6'd1;
        tick();
        check("to_req", mem_req, 1);
        state = 6'd0;
        for (int i = 0; i < 14; i++) tick();
        check("to_req_14", mem_req, 1);
        check("to_err_14", fetch_err, 0);
        tick();
        check("to_req_off", mem_req, 0);
        check("to_ir", IR, 16'd0);
        check("to_err", fetch_err, 1);
        check("to_done", fetch_done, 1);
        check("to_pc", PC, 8'h11);
        check("to_busy", fetch_busy, 0);
        tick();
        check("to_done_off", fetch_done, 0);
        check("to_err_sticky", fetch_err, 1);
        mem[8'h11] = 16'h0042;
        mem_ack = 1'b1;
        state = 6'd1;
        tick();
        state = 6'd0;
        tick();
        check("to_ir_after", IR, 16'h0042);
        check("to_err_after", fetch_err, 1);
        mem_ack = 1'b0;
`else
        state = 6'd1;
        tick();
        state = 6'd0;
        for (int i = 0; i < 20; i++) tick();
        check("nt_req_wait", mem_req, 1);
        check("nt_busy_wait", fetch_busy, 1);
        check("nt_err", fetch_err, 0);
        check("nt_ir_hold", IR, 16'h0F0F);
`endif

        // asynchronous reset in the middle of a request
        state = 6'd1;
        tick();
        check("ar_req_pre", mem_req, 1);
        state = 6'd0;
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_req", mem_req, 0);
        check("ar_ir", IR, 0);
        check("ar_pc", PC, 0);
        check("ar_busy", fetch_busy, 0);
        check("ar_err", fetch_err, 0);
        check("ar_addr", mem_addr, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check("ar_idle", mem_req, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
